mul_approx_pipe: RTL and testbench
==================================

Name: mul_approx_pipe

Overview:
- Parametrised, pipelined successor to the library's fixed 8x8 combinational approximate multipliers.
- Unsigned WIDTH x WIDTH multiply with a per-transaction mode: exact, or column-truncated with constant bias compensation.
- Adds a registered pipeline, a valid/ready handshake and an approximate-use counter.
- Sits between operand producers (filters, MAC arrays) and accumulators in the approximate-arithmetic datapaths.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH.
- TRUNC, 4, number of LSB partial-product columns (column index i+j < TRUNC) dropped in approximate mode. Range 0..2*WIDTH-1.
- COMP, 8, constant added in approximate mode when both operands are nonzero. Must satisfy COMP < 2^(WIDTH+1)-1, so no overflow is possible.
- STAGES, 3, pipeline register stages; minimum 1.
- CNTW, 32, approximate-transaction counter width.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- MODE  in  1  0 = exact, 1 = approximate; sampled with A/B.
- IN_VALID  in  1  operand beat valid.
- IN_READY  out  1  block accepts beat this cycle.
- O  out  2*WIDTH  product.
- OUT_VALID  out  1  O valid.
- OUT_READY  in  1  consumer accepts O.
- CNT_CLR  in  1  synchronous clear of CNT_APPROX.
- CNT_APPROX  out  CNTW  number of accepted MODE=1 beats.

Behaviour:
- Reset (asynchronous, RST=1): all stage valid bits 0, all data registers 0, O=0, OUT_VALID=0, CNT_APPROX=0. IN_READY is combinational and reads 1 during/after reset.
- Advance enable: EN = OUT_READY | ~OUT_VALID. IN_READY = EN.
  - All stages shift together when EN=1 and hold when EN=0.
  - Bubbles are not collapsed.
- Acceptance: a beat is accepted when IN_VALID & IN_READY. Stage-0 valid loads IN_VALID on EN, so an invalid cycle inserts a bubble.
- Latency: exactly STAGES cycles from acceptance to OUT_VALID when OUT_READY stays high. Throughput is 1 beat/cycle.
- O and OUT_VALID are held stable while OUT_VALID & ~OUT_READY, and never change without a handshake.
- Exact mode: O = A*B, full 2*WIDTH bits.
- Approximate mode:
  - If A==0 or B==0: O = 0.
  - Otherwise O = sum of a_i*b_j*2^(i+j) over i+j >= TRUNC, plus COMP.
  - TRUNC=0 with COMP=0 equals exact.
- Arithmetic placement: computed in stage 0 from the registered-in operands or combinationally before stage 0. The pipeline registers may split the adder tree, but the result must be bit-identical.
- Counter:
  - CNT_APPROX increments on every accepted beat with MODE=1.
  - Wraps modulo 2^CNTW.
  - CNT_CLR=1 clears it to 0. If an increment occurs in the same cycle, the result is 0 (clear wins).
- IN_VALID high with IN_READY low: the beat is not taken, the counter does not count, and the producer must hold it.
- Reset mid-operation: all in-flight beats are discarded and nothing is emitted after reset release until new beats are accepted.

Decomposition:
- Package mul_approx_pkg:
  - MODE_EXACT/MODE_APPROX constants.
  - Function prod_w(WIDTH) = 2*WIDTH.
  - Elaboration-time check function for the TRUNC/COMP/STAGES legality ranges.
- Sub-module pp_trunc_sum:
  - Combinational; parameters WIDTH and TRUNC.
  - Produces the masked partial-product sum.
  - The top level adds COMP, handles the zero-operand override, and owns the mode mux, pipeline and counter.

Test Plan:
1. Exact mode: A=15, B=15, MODE=0 (defaults) -> O=225, OUT_VALID exactly 3 cycles after acceptance.
2. Approximate mode:
   - A=15, B=15, MODE=1 -> O=184 (225-49+8).
   - A=255, B=255 -> O=64984.
   - A=16, B=16 -> O=264.
3. Zero override and counter: A=0, B=200, MODE=1 -> O=0 and CNT_APPROX increments by 1. Also A=1, B=1, MODE=1 -> O=8.
4. Backpressure: stream 6 beats back-to-back, hold OUT_READY=0 for 4 cycles mid-stream.
   - IN_READY drops, O stable while stalled.
   - All 6 results in order, none lost or duplicated.
5. Counter: 3 MODE=1 beats, then CNT_CLR asserted in the same cycle as a 4th MODE=1 acceptance -> CNT_APPROX=0 next cycle. A following MODE=1 beat gives 1.
6. Reset: assert RST while 2 beats are in flight -> OUT_VALID=0 and CNT_APPROX=0 immediately (asynchronous), and no stale output after release. Also sweep WIDTH=4/TRUNC=0/COMP=0/STAGES=1 exhaustively against the exact product.

Source files
------------

// File: rtl/mul_approx_pkg.sv
// Shared constants and elaboration helpers for the pipelined approximate multiplier.
package mul_approx_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction

  // COMP bound keeps (2^W-1)^2 + COMP inside 2*W bits even with TRUNC=0.
  function automatic bit params_legal(input int width, input int trunc,
                                      input longint comp, input int stages);
    longint comp_lim;
    comp_lim = (longint'(1) << (width + 1)) - 1;
    return (width >= 1) && (trunc >= 0) && (trunc <= 2 * width - 1) &&
           (comp >= 0) && (comp < comp_lim) && (stages >= 1);
  endfunction

endpackage

// File: rtl/mul_approx_pipe_pp_trunc_sum.sv
// Combinational sum of the partial products whose column index i+j is at least TRUNC.
module pp_trunc_sum
  import mul_approx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TRUNC = 4
) (
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic [prod_w(WIDTH)-1:0] sum
);

  localparam int PW = prod_w(WIDTH);

  always_comb begin
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (i + j >= TRUNC) begin
          sum = sum + (PW'(a[i] & b[j]) << (i + j));
        end
      end
    end
  end

endmodule

// File: rtl/mul_approx_pipe.sv
// Pipelined WIDTH x WIDTH unsigned multiplier with per-beat exact/truncated mode
// and a counter of accepted approximate beats.
module mul_approx_pipe
  import mul_approx_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int TRUNC  = 4,
  parameter int COMP   = 8,
  parameter int STAGES = 3,
  parameter int CNTW   = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [WIDTH-1:0]         A,
  input  logic [WIDTH-1:0]         B,
  input  logic                     MODE,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  output logic [prod_w(WIDTH)-1:0] O,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  input  logic                     CNT_CLR,
  output logic [CNTW-1:0]          CNT_APPROX
);

  localparam int PW = prod_w(WIDTH);
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  if (!params_legal(WIDTH, TRUNC, COMP, STAGES)) begin : g_bad_params
    $error("mul_approx_pipe: illegal WIDTH/TRUNC/COMP/STAGES combination");
  end

  logic          en;
  logic [PW-1:0] trunc_sum;
  logic [PW-1:0] exact_prod;
  logic [PW-1:0] approx_prod;
  logic [PW-1:0] result;
  logic [STAGES-1:0] vld;
  logic [PW-1:0]     data [STAGES];

  pp_trunc_sum #(
    .WIDTH(WIDTH),
    .TRUNC(TRUNC)
  ) u_pp_trunc_sum (
    .a  (A),
    .b  (B),
    .sum(trunc_sum)
  );

  // Handshake: a beat moves on a side when valid & ready are both high at the
  // rising edge. The whole pipe advances together when the output slot is empty
  // or being drained (en); bubbles ride along rather than being squeezed out.
  assign en       = OUT_READY | ~OUT_VALID;
  assign IN_READY = en;

  assign exact_prod  = PW'(A) * PW'(B);
  assign approx_prod = ((A == '0) || (B == '0)) ? '0 : trunc_sum + PW'(COMP);
  assign result      = (MODE == MODE_APPROX) ? approx_prod : exact_prod;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld <= '0;
      for (int s = 0; s < STAGES; s++) begin
        data[s] <= '0;
      end
    end else if (en) begin
      vld[0]  <= IN_VALID;
      data[0] <= result;
      for (int s = 1; s < STAGES; s++) begin
        vld[s]  <= vld[s-1];
        data[s] <= data[s-1];
      end
    end
  end

  assign O         = data[STAGES-1];
  assign OUT_VALID = vld[STAGES-1];

  // Clear has priority over a coincident approximate acceptance.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CNT_APPROX <= '0;
    end else if (CNT_CLR) begin
      CNT_APPROX <= '0;
    end else if (IN_VALID && en && (MODE == MODE_APPROX)) begin
      CNT_APPROX <= CNT_APPROX + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_mul_approx_pipe.sv
// Directed bench for mul_approx_pipe: vector table, backpressure stream, counter,
// reset and an exhaustive sweep of a small exact configuration.
module tb_mul_approx_pipe;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        mode;
    logic [15:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  a_in, b_in;
  logic        mode_in, in_valid, in_ready, out_ready, cnt_clr;
  logic [15:0] o;
  logic        out_valid;
  logic [31:0] cnt;

  logic [3:0]  a4, b4;
  logic        mode4, in_valid4, in_ready4, out_ready4, cnt_clr4;
  logic [7:0]  o4;
  logic        out_valid4;
  logic [31:0] cnt4;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_cnt;
  logic [15:0] exp_q[$];
  logic [7:0]  exp_q4[$];
  vec_t        vecs[10];

  always #5 clk = ~clk;

  mul_approx_pipe dut (
    .CLK(clk), .RST(rst), .A(a_in), .B(b_in), .MODE(mode_in),
    .IN_VALID(in_valid), .IN_READY(in_ready), .O(o), .OUT_VALID(out_valid),
    .OUT_READY(out_ready), .CNT_CLR(cnt_clr), .CNT_APPROX(cnt)
  );

  mul_approx_pipe #(.WIDTH(4), .TRUNC(0), .COMP(0), .STAGES(1), .CNTW(32)) dut4 (
    .CLK(clk), .RST(rst), .A(a4), .B(b4), .MODE(mode4),
    .IN_VALID(in_valid4), .IN_READY(in_ready4), .O(o4), .OUT_VALID(out_valid4),
    .OUT_READY(out_ready4), .CNT_CLR(cnt_clr4), .CNT_APPROX(cnt4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at a falling edge with the pipe drained.
  task automatic run_vector(input vec_t v, input int k);
    int lat;
    a_in = v.a; b_in = v.b; mode_in = v.mode; in_valid = 1'b1; out_ready = 1'b1;
    #1 check($sformatf("vec%0d_in_ready", k), in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    if (v.mode) exp_cnt++;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("vec%0d_latency", k), lat, 3);
    check($sformatf("vec%0d_o", k), o, v.exp);
    check($sformatf("vec%0d_cnt", k), cnt, exp_cnt);
    @(negedge clk);
  endtask

  task automatic drive_beat(input logic [7:0] a, input logic [7:0] b,
                            input logic mode, input logic clr);
    a_in = a; b_in = b; mode_in = mode; in_valid = 1'b1; cnt_clr = clr;
    @(negedge clk);
    in_valid = 1'b0; cnt_clr = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent, got, stale, lat;
    logic stall_prev;
    logic [15:0] held_o;

    a_in = '0; b_in = '0; mode_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    a4 = '0; b4 = '0; mode4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b1; cnt_clr4 = 1'b0;
    exp_cnt = '0;

    vecs[0] = '{8'd15,  8'd15,  1'b0, 16'd225};
    vecs[1] = '{8'd15,  8'd15,  1'b1, 16'd184};
    vecs[2] = '{8'd255, 8'd255, 1'b1, 16'd64984};
    vecs[3] = '{8'd16,  8'd16,  1'b1, 16'd264};
    vecs[4] = '{8'd0,   8'd200, 1'b1, 16'd0};
    vecs[5] = '{8'd1,   8'd1,   1'b1, 16'd8};
    vecs[6] = '{8'd255, 8'd255, 1'b0, 16'd65025};
    vecs[7] = '{8'd200, 8'd0,   1'b0, 16'd0};
    vecs[8] = '{8'd3,   8'd5,   1'b1, 16'd8};
    vecs[9] = '{8'd100, 8'd3,   1'b1, 16'd296};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_o", o, 0);
    check("rst_cnt", cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 10; k++) run_vector(vecs[k], k);

    // Backpressure stream: six beats back-to-back, output stalled four cycles
    exp_q.delete();
    sent = 0; got = 0; stall_prev = 1'b0; held_o = '0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      out_ready = !(c >= 5 && c < 9);
      if (sent < 6) begin
        a_in = vecs[sent].a; b_in = vecs[sent].b; mode_in = vecs[sent].mode; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stall_prev) begin
        check("stall_o_hold", o, held_o);
        check("stall_valid_hold", out_valid, 1);
      end
      if (out_valid && !out_ready) check("stall_in_ready_low", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("stream_extra", 1, 0);
        else check($sformatf("stream_o%0d", got), o, exp_q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(vecs[sent].exp);
        if (vecs[sent].mode) exp_cnt++;
        sent++;
      end
      stall_prev = out_valid && !out_ready;
      held_o = o;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream_got", got, 6);
    check("stream_sent", sent, 6);
    check("stream_q_empty", exp_q.size(), 0);
    check("stream_cnt", cnt, exp_cnt);

    // Counter clear, clear-wins, and count after clear
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("clr_only", cnt, 0);
    for (int k = 0; k < 3; k++) drive_beat(8'd15, 8'd15, 1'b1, 1'b0);
    check("cnt_three", cnt, 3);
    drive_beat(8'd15, 8'd15, 1'b1, 1'b1);
    check("clr_wins", cnt, 0);
    drive_beat(8'd1, 8'd1, 1'b1, 1'b0);
    check("clr_then_inc", cnt, 1);
    repeat (5) @(negedge clk);

    // Asynchronous reset with two beats in flight
    out_ready = 1'b0;
    drive_beat(8'd15, 8'd15, 1'b1, 1'b0);
    drive_beat(8'd16, 8'd16, 1'b1, 1'b0);
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_cnt", cnt, 3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_o", o, 0);
    check("async_rst_cnt", cnt, 0);
    check("async_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale_output", stale, 0);
    exp_cnt = '0;
    run_vector(vecs[2], 10);

    // Exhaustive sweep of the WIDTH=4, TRUNC=0, COMP=0, STAGES=1 instance
    exp_q4.delete();
    for (int k = 0; k <= 256; k++) begin
      if (k < 256) begin
        a4 = 4'(k); b4 = 4'(k >> 4); mode4 = 1'($urandom_range(0, 1)); in_valid4 = 1'b1;
      end else begin
        in_valid4 = 1'b0;
      end
      #1;
      if (out_valid4) begin
        if (exp_q4.size() == 0) check("sweep_extra", 1, 0);
        else check("sweep_o", o4, exp_q4.pop_front());
      end
      if (in_valid4 && in_ready4) exp_q4.push_back(8'(a4) * 8'(b4));
      @(negedge clk);
    end
    check("sweep_drained", exp_q4.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
